// File: rtl/eeg_loader_pkg.sv
// Shared sizes, types and helpers for the EEG epoch loader (package Defines).
// The loader top also honours the optional EEG_OVERRUN_FLAG_EN build macro.
`timescale 1ns/1ps
package Defines;

    localparam int NUM_PATCHES          = 60;
    localparam int PATCH_LEN            = 64;
    localparam int ADC_BITWIDTH         = 16;
    localparam int Q_STO_INT_RES_DOUBLE = 20;
    localparam int EEG_NUM_SAMPLES      = NUM_PATCHES * PATCH_LEN;

    typedef logic [ADC_BITWIDTH-1:0]                   AdcData_t;
    typedef logic [15:0]                               IntResAddr_t;
    typedef logic signed [29:0]                        IntResDouble_t;
    typedef logic [$clog2(EEG_NUM_SAMPLES+1)-1:0]      SampleCount_t;

    typedef enum logic {SINGLE_WIDTH, DOUBLE_WIDTH} DataWidth_t;

    typedef enum logic {EEG_INPUT_MEM, FEATURE_MEM} MemRegion_t;
    localparam IntResAddr_t mem_map [2] = '{16'd0, 16'd3840};

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH} EegLoaderState_t;

    typedef struct packed {
        IntResAddr_t   addr;
        IntResDouble_t data;
    } EegWrite_t;

    // Inverting the MSB is the same as subtracting mid-scale from an offset-binary word.
    function automatic IntResDouble_t adc_to_q(input AdcData_t s);
        logic signed [ADC_BITWIDTH-1:0] centred;
        IntResDouble_t                  wide;
        centred = {~s[ADC_BITWIDTH-1], s[ADC_BITWIDTH-2:0]};
        wide    = IntResDouble_t'(centred);
        return wide <<< (Q_STO_INT_RES_DOUBLE - (ADC_BITWIDTH - 1));
    endfunction

endpackage

// File: rtl/eeg_loader_sample_fifo.sv
// Two-entry FIFO of pending (address, data) writes with registered head output.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
`timescale 1ns/1ps
module eeg_sample_fifo
    import Defines::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  EegWrite_t push_data,
    input  logic      pop,
    output EegWrite_t head,
    output logic      full,
    output logic      empty
);

    EegWrite_t  entries [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] level;
    logic       do_pop;
    logic       do_push;

    assign do_pop  = pop & (level != 2'd0);
    assign do_push = push & ((level != 2'd2) | do_pop);

    // NOTE: storage is reset as well so the head reads zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries[0] <= '0;
            entries[1] <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            level      <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments let every register see pre-edge values.
            if (do_push) begin
                entries[wr_ptr] <= push_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            level <= level + 2'(do_push) - 2'(do_pop);
        end
    end

    assign head  = entries[rd_ptr];
    assign full  = (level == 2'd2);
    assign empty = (level == 2'd0);

endmodule

// File: rtl/eeg_loader.sv
// Loads one EEG epoch: converts ADC samples to Q20 and streams them to memory.
// Build macro EEG_OVERRUN_FLAG_EN adds a sticky overrun output.
`timescale 1ns/1ps
module eeg_loader
    import Defines::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          new_sample,
    input  AdcData_t      sample,
    output logic          wr_req,
    input  logic          wr_gnt,
    output IntResAddr_t   wr_addr,
    output IntResDouble_t wr_data,
    output DataWidth_t    wr_width,
    output logic          busy,
    output logic          done
`ifdef EEG_OVERRUN_FLAG_EN
    ,
    output logic          overrun
`endif
);

    EegLoaderState_t state_q;
    EegLoaderState_t state_d;
    SampleCount_t    count_q;
    EegWrite_t       fifo_in;
    EegWrite_t       fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            take;
    logic            accept;
    logic            start_ok;

    assign pop    = wr_req & wr_gnt;
    assign take   = (state_q == LOAD) & new_sample;
    assign accept = take & (~fifo_full | pop);

    assign fifo_in = '{addr: mem_map[EEG_INPUT_MEM] + IntResAddr_t'(count_q),
                       data: adc_to_q(sample)};

    eeg_sample_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (fifo_in),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        done     = 1'b0;
        start_ok = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_ok = 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                busy = 1'b1;
                if (accept && count_q == SampleCount_t'(EEG_NUM_SAMPLES - 1)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (fifo_empty) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (start_ok) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= count_q + SampleCount_t'(1);
        end
    end

`ifdef EEG_OVERRUN_FLAG_EN
    logic drop;
    assign drop = take & fifo_full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (start_ok) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end
    end
`endif

    assign wr_req   = ~fifo_empty;
    assign wr_addr  = fifo_head.addr;
    assign wr_data  = fifo_head.data;
    assign wr_width = DOUBLE_WIDTH;

endmodule

// File: tb/tb_eeg_loader.sv
// Self-checking bench for eeg_loader against a queue-based epoch model.
// Works with or without EEG_OVERRUN_FLAG_EN defined.
`timescale 1ns/1ps
module tb_eeg_loader;
    import Defines::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          new_sample = 1'b0;
    AdcData_t      sample = '0;
    logic          wr_req;
    logic          wr_gnt = 1'b0;
    IntResAddr_t   wr_addr;
    IntResDouble_t wr_data;
    DataWidth_t    wr_width;
    logic          busy;
    logic          done;
`ifdef EEG_OVERRUN_FLAG_EN
    logic          overrun;
`endif

    always #5 clk = ~clk;

    eeg_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .new_sample (new_sample),
        .sample     (sample),
        .wr_req     (wr_req),
        .wr_gnt     (wr_gnt),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_width   (wr_width),
        .busy       (busy),
        .done       (done)
`ifdef EEG_OVERRUN_FLAG_EN
        ,
        .overrun    (overrun)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 loading, 2 draining; q holds writes not yet granted.
    typedef struct {
        IntResAddr_t   addr;
        IntResDouble_t data;
    } exp_t;
    exp_t q[$];
    int   ph = 0;
    int   cnt = 0;
    int   m_drops = 0;
    bit   m_ovr = 1'b0;
    bit   mon_en = 1'b0;
    int   dut_writes = 0;
    int   dut_done = 0;

    function automatic IntResDouble_t conv(input int s);
        return IntResDouble_t'((s - 32768) * 32);
    endfunction

    always @(negedge clk) begin : monitor
        bit exp_done;
        bit pop;
        if (mon_en && rst_n) begin
            if (wr_req === 1'b1 && wr_gnt === 1'b1) dut_writes++;
            if (done === 1'b1) dut_done++;
            exp_done = (ph == 2 && q.size() == 0);
            checks++;
            if (wr_req !== (q.size() != 0)) begin
                errors++;
                $display("FAIL wr_req t=%0t got %b want %b", $time, wr_req, q.size() != 0);
            end
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL done t=%0t got %b want %b", $time, done, exp_done);
            end
            checks++;
            if (busy !== (ph != 0 && !exp_done)) begin
                errors++;
                $display("FAIL busy t=%0t got %b want %b", $time, busy, ph != 0 && !exp_done);
            end
`ifdef EEG_OVERRUN_FLAG_EN
            checks++;
            if (overrun !== m_ovr) begin
                errors++;
                $display("FAIL overrun t=%0t got %b want %b", $time, overrun, m_ovr);
            end
`endif
            pop = wr_gnt && q.size() > 0;
            if (pop) begin
                checks++;
                if (wr_addr !== q[0].addr || wr_data !== q[0].data) begin
                    errors++;
                    $display("FAIL write t=%0t got addr %0d data %0d want addr %0d data %0d",
                             $time, wr_addr, wr_data, q[0].addr, q[0].data);
                end
                void'(q.pop_front());
            end
            if (ph == 1 && new_sample) begin
                if (q.size() < 2) begin
                    q.push_back('{IntResAddr_t'(int'(mem_map[EEG_INPUT_MEM]) + cnt),
                                  conv(int'(sample))});
                    cnt++;
                end else begin
                    m_drops++;
                    m_ovr = 1'b1;
                end
            end
            if (ph == 0 && start) begin
                ph = 1;
                cnt = 0;
                m_ovr = 1'b0;
            end else if (ph == 1 && cnt == EEG_NUM_SAMPLES) begin
                ph = 2;
            end else if (exp_done) begin
                ph = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input AdcData_t s);
        new_sample = 1'b1;
        sample     = s;
        tick();
        new_sample = 1'b0;
    endtask

    task automatic model_clear();
        q.delete();
        ph    = 0;
        cnt   = 0;
        m_ovr = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_clear();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && ph != 0; i++) tick();
        checks++;
        if (ph != 0) begin
            errors++;
            $display("FAIL idle_timeout got phase %0d want 0 within %0d cycles", ph, budget);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (wr_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            wr_addr !== '0 || wr_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs got req %b busy %b done %b addr %0d data %0d want all 0",
                     wr_req, busy, done, wr_addr, wr_data);
        end
        checks++;
        if (wr_width !== DOUBLE_WIDTH) begin
            errors++;
            $display("FAIL wr_width got %0d want %0d", wr_width, DOUBLE_WIDTH);
        end
        tick();
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_conversion();
        AdcData_t      vals [3];
        IntResDouble_t exps [3];
        vals = '{16'h0000, 16'h8000, 16'hFFFF};
        exps = '{-30'sd1048576, 30'sd0, 30'sd1048544};
        wr_gnt = 1'b1;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            send(vals[i]);
            checks++;
            if (wr_req !== 1'b1 || wr_addr !== IntResAddr_t'(i) || wr_data !== exps[i]) begin
                errors++;
                $display("FAIL conversion_%0d got req %b addr %0d data %0d want 1 %0d %0d",
                         i, wr_req, wr_addr, wr_data, i, exps[i]);
            end
        end
        apply_reset();
    endtask

    task automatic test_ignored_inputs();
        wr_gnt = 1'b1;
        for (int i = 0; i < 5; i++) send(AdcData_t'($urandom));
        tick();
        checks++;
        if (wr_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_samples got req %b busy %b want 0 0", wr_req, busy);
        end
        pulse_start();
        for (int i = 0; i < 5; i++) send(AdcData_t'($urandom));
        pulse_start();
        for (int i = 0; i < 5; i++) send(AdcData_t'($urandom));
        tick();
        send(16'h1234);
        checks++;
        if (wr_addr !== 16'd10 || wr_data !== conv(32'h1234)) begin
            errors++;
            $display("FAIL start_in_load got addr %0d data %0d want 10 %0d",
                     wr_addr, wr_data, conv(32'h1234));
        end
        apply_reset();
    endtask

    task automatic test_overrun();
        int d0;
        d0 = m_drops;
        wr_gnt = 1'b0;
        pulse_start();
        send(16'h0100);
        send(16'h0200);
        send(16'h0300);
        tick();
        checks++;
        if (wr_req !== 1'b1 || wr_addr !== 16'd0 || m_drops - d0 != 1) begin
            errors++;
            $display("FAIL overrun_hold got req %b addr %0d drops %0d want 1 0 1",
                     wr_req, wr_addr, m_drops - d0);
        end
`ifdef EEG_OVERRUN_FLAG_EN
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_flag got %b want 1", overrun);
        end
`endif
        wr_gnt = 1'b1;
        tick();
        checks++;
        if (wr_addr !== 16'd1 || wr_data !== conv(32'h0200)) begin
            errors++;
            $display("FAIL overrun_second got addr %0d data %0d want 1 %0d",
                     wr_addr, wr_data, conv(32'h0200));
        end
        tick();
        send(16'h0400);
        checks++;
        if (wr_addr !== 16'd2 || wr_data !== conv(32'h0400)) begin
            errors++;
            $display("FAIL overrun_count got addr %0d data %0d want 2 %0d",
                     wr_addr, wr_data, conv(32'h0400));
        end
        apply_reset();
    endtask

    task automatic test_reset_mid_load();
        wr_gnt = 1'b1;
        pulse_start();
        for (int i = 0; i < 100; i++) send(AdcData_t'($urandom));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if (wr_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            wr_addr !== '0 || wr_data !== '0) begin
            errors++;
            $display("FAIL async_reset got req %b busy %b done %b addr %0d data %0d want all 0",
                     wr_req, busy, done, wr_addr, wr_data);
        end
        tick();
        rst_n = 1'b1;
        send(16'h7777);
        tick();
        checks++;
        if (wr_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_reset got req %b busy %b want 0 0", wr_req, busy);
        end
        pulse_start();
        send(16'hABCD);
        checks++;
        if (wr_addr !== 16'd0 || wr_data !== conv(32'hABCD)) begin
            errors++;
            $display("FAIL restart_addr got addr %0d data %0d want 0 %0d",
                     wr_addr, wr_data, conv(32'hABCD));
        end
        apply_reset();
    endtask

    task automatic test_full_epoch();
        int w0;
        int d0;
        w0 = dut_writes;
        d0 = dut_done;
        wr_gnt = 1'b1;
        pulse_start();
        for (int i = 0; i < EEG_NUM_SAMPLES; i++) begin
            send(AdcData_t'($urandom));
            repeat (3) tick();
        end
        wait_idle(50);
        tick();
        checks++;
        if (dut_writes - w0 != EEG_NUM_SAMPLES || dut_done - d0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_epoch got writes %0d done %0d busy %b want %0d 1 0",
                     dut_writes - w0, dut_done - d0, busy, EEG_NUM_SAMPLES);
        end
    endtask

    task automatic test_back_to_back();
        int w0;
        int d0;
        int x0;
        w0 = dut_writes;
        d0 = dut_done;
        x0 = m_drops;
        wr_gnt = 1'b1;
        pulse_start();
        new_sample = 1'b1;
        for (int i = 0; i < EEG_NUM_SAMPLES; i++) begin
            sample = AdcData_t'($urandom);
            tick();
        end
        new_sample = 1'b0;
        wait_idle(20);
        tick();
        checks++;
        if (dut_writes - w0 != EEG_NUM_SAMPLES || dut_done - d0 != 1 || m_drops != x0) begin
            errors++;
            $display("FAIL back_to_back got writes %0d done %0d drops %0d want %0d 1 0",
                     dut_writes - w0, dut_done - d0, m_drops - x0, EEG_NUM_SAMPLES);
        end
    endtask

    task automatic test_random();
        int w0;
        int d0;
        w0 = dut_writes;
        d0 = dut_done;
        pulse_start();
        for (int i = 0; i < 40000 && ph == 1; i++) begin
            new_sample = 1'($urandom_range(0, 1));
            sample     = AdcData_t'($urandom);
            wr_gnt     = ($urandom_range(0, 3) != 0);
            tick();
        end
        new_sample = 1'b0;
        wr_gnt     = 1'b1;
        wait_idle(20);
        tick();
        checks++;
        if (dut_writes - w0 != EEG_NUM_SAMPLES || dut_done - d0 != 1) begin
            errors++;
            $display("FAIL random_epoch got writes %0d done %0d want %0d 1",
                     dut_writes - w0, dut_done - d0, EEG_NUM_SAMPLES);
        end
    endtask

    initial begin
        test_reset();
        test_conversion();
        test_ignored_inputs();
        test_overrun();
        test_reset_mid_load();
        test_full_epoch();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
